// File: rtl/mips_regfile_param.sv
// Parameterised MIPS-style register file: two combinational read ports, one
// byte-masked write port, and a sequential clear FSM that zeroes every entry.

module mips_regfile_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module mips_regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   read_reg_1,
  input  logic [ADDR_W-1:0]   read_reg_2,
  output logic [DATA_W-1:0]   read_data_1,
  output logic [DATA_W-1:0]   read_data_2,
  input  logic [ADDR_W-1:0]   write_reg,
  input  logic [DATA_W-1:0]   write_data,
  input  logic                signal_reg_write,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic                clear_req,
  output logic                ready
);
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [NUM_LANES-1:0][7:0] wr_old, wr_new, wr_merged;
  logic                      wr_zero_hit;
  logic                      wr_en;

  assign wr_old      = mem_q[write_reg];
  assign wr_new      = write_data;
  assign wr_zero_hit = (ZERO_REG != 0) && (write_reg == '0);
  // A clear request on the same edge takes priority and the write is lost.
  assign wr_en = (state_q == READY) && signal_reg_write && !clear_req && !wr_zero_hit;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mips_regfile_lane u_lane (
      .old_byte (wr_old[g]),
      .new_byte (wr_new[g]),
      .en       (byte_en[g]),
      .merged   (wr_merged[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
    ready_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  // Storage carries no reset; its contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem_q[clr_idx_q] <= '0;
    else if (wr_en)
      mem_q[write_reg] <= wr_merged;
  end

  assign ready = ready_q;

  always_comb begin
    read_data_1 = '0;
    if (state_q == READY && !((ZERO_REG != 0) && (read_reg_1 == '0))) begin
      if (wr_en && (read_reg_1 == write_reg)) read_data_1 = wr_merged;
      else                                    read_data_1 = mem_q[read_reg_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (state_q == READY && !((ZERO_REG != 0) && (read_reg_2 == '0))) begin
      if (wr_en && (read_reg_2 == write_reg)) read_data_2 = wr_merged;
      else                                    read_data_2 = mem_q[read_reg_2];
    end
  end

endmodule

// File: doc/mips_regfile_param.md
MIPS_REGFILE_PARAM -- requirements
Module: mips_regfile_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-004 SHALL provide port clk  input  1  single clock, rising edge.
REQ-005 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port read_reg_1, read_reg_2  input  ADDR_W  read addresses.
REQ-007 SHALL provide port read_data_1, read_data_2  output  DATA_W  read data, combinational.
REQ-008 SHALL provide port write_reg  input  ADDR_W  write address.
REQ-009 SHALL provide port write_data  input  DATA_W  write data.
REQ-010 SHALL provide port signal_reg_write  input  1  write enable.
REQ-011 SHALL provide port byte_en  input  DATA_W/8  per-byte write mask, where bit i covers bits [8i+7:8i].
REQ-012 SHALL provide port clear_req  input  1  single-cycle request to re-zero the whole file.
REQ-013 SHALL provide port ready  output  1  high when the file is accepting reads and writes.

Function
REQ-014 SHALL implement FSM states CLEAR and READY, with a clear index counter clr_idx of ADDR_W bits.
REQ-015 In CLEAR, the block SHALL write zero to entry clr_idx on each rising edge and then increment clr_idx.
REQ-016 CLEAR SHALL transition to READY on the edge that zeroes entry DEPTH-1; clr_idx wraps to 0 on that edge.
REQ-017 In READY, clear_req=1 at a rising edge SHALL move the FSM to CLEAR with clr_idx=0.
REQ-018 clear_req SHALL be ignored while the FSM is already in CLEAR; the clear sequence is not restarted.
REQ-019 ready SHALL be 1 exactly when state==READY; it is a registered output.
REQ-020 In READY with signal_reg_write=1, the block SHALL update only the bytes of entry write_reg whose byte_en bit is 1, on the rising edge.
REQ-021 Writes SHALL be dropped in CLEAR and on the edge where clear_req moves the FSM READY->CLEAR; clear wins over write.
REQ-022 With ZERO_REG=1, writes to entry 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-023 In CLEAR, both read ports SHALL return 0 regardless of address.
REQ-024 Write-through bypass: in READY, if signal_reg_write=1, clear_req=0, read_reg_n==write_reg, and the address is not a discarded entry 0, read_data_n SHALL equal the stored value with the enabled bytes replaced by write_data in the same cycle.
REQ-025 Both read ports SHALL operate independently; identical addresses on both ports SHALL return identical data.
REQ-026 byte_en=0 with signal_reg_write=1 SHALL leave storage and read data unchanged, and bypass has no effect.
REQ-027 The block SHALL NOT perform file I/O or use simulation-only initialisation; contents are defined solely by the clear sequence and writes.

Reset
REQ-028 On rst_n=0, asynchronously and independent of clk, the block SHALL set state=CLEAR, clr_idx=0, ready=0, and force read_data_1 and read_data_2 to 0.
REQ-029 After rst_n deasserts, ready SHALL rise after exactly DEPTH rising edges (32 at default parameters).
REQ-030 rst_n asserted during CLEAR or during a write SHALL abort the operation and restart the clear sequence from index 0; a partial write is not guaranteed.

Verification
REQ-031 Reset release -> ready=0 for 32 edges and 1 after the 32nd; reads of addresses 1..31 then return 0.
REQ-032 Write 0xDEADBEEF to reg 5 with byte_en=4'b1111, then write 0x000000AA with byte_en=4'b0001 -> reg 5 reads 0xDEADBEAA.
REQ-033 Write 0x12345678 to reg 0 -> reg 0 reads 0; a same-cycle read of reg 0 returns 0 with no bypass.
REQ-034 Write 0xCAFEF00D to reg 7 while read_reg_1=7 in the same cycle -> read_data_1=0xCAFEF00D before the edge.
REQ-035 In READY, assert clear_req together with a write of 0x1 to reg 3 -> ready=0 for 32 cycles, reg 3 reads 0, and the write is lost; clear_req pulsed mid-CLEAR does not extend the 32-cycle duration.
REQ-036 Assert rst_n=0 at clear index 10 -> outputs are 0 immediately, and ready rises 32 edges after rst_n is released.
